// File: rtl/shift_pkg.sv
// Shared types for the shift sequencer and its shift register datapath.
//   funct_t     : function code driven into shift_register
//   seq_state_t : sequencer FSM states (also exported on the debug state port)
package shift_pkg;

    typedef enum logic [1:0] {
        NA    = 2'b00,  // hold contents
        LOAD  = 2'b01,  // parallel load from word_i
        LEFT  = 2'b10,  // shift toward MSB, serial_i enters at bit 0
        RIGHT = 2'b11   // shift toward LSB, serial_i enters at bit WIDTH-1
    } funct_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } seq_state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between a word-side client and shift_sequencer.
// Handshake: a transfer is accepted on a rising clk edge where start_i and
// ready_o are both 1; start_i while ready_o is 0 is ignored (no queueing).
// mode_i, msb_first_i and word_i are only looked at on that accepting edge.
//   master : client side (drives start/mode/order/word/serial_i)
//   slave  : sequencer side (drives ready/busy/done/word/serial_o/state)
interface shift_sequencer_if
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
);
    logic             start_i;
    logic             ready_o;
    logic             mode_i;
    logic             msb_first_i;
    logic [WIDTH-1:0] word_i;
    logic             serial_i;
    logic             serial_o;
    logic [WIDTH-1:0] word_o;
    logic             word_valid_o;
    logic             done_o;
    logic             busy_o;
    seq_state_t       state_o;   // debug view of the sequencer FSM

    modport master (
        output start_i, mode_i, msb_first_i, word_i, serial_i,
        input  ready_o, serial_o, word_o, word_valid_o, done_o, busy_o, state_o
    );

    modport slave (
        input  start_i, mode_i, msb_first_i, word_i, serial_i,
        output ready_o, serial_o, word_o, word_valid_o, done_o, busy_o, state_o
    );
endinterface

// File: rtl/shift_register.sv
// Universal shift register used as the sequencer datapath.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (contents -> 0)
//   funct_i   : NA hold / LOAD word_i / LEFT shift / RIGHT shift
//   word_i    : parallel load value
//   serial_i  : bit shifted in (bit 0 on LEFT, bit WIDTH-1 on RIGHT)
//   out_o     : current contents
module shift_register
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  funct_t           funct_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             serial_i,
    output logic [WIDTH-1:0] out_o
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        case (funct_i)
            LOAD:    q_d = word_i;
            LEFT:    q_d = {q_q[WIDTH-2:0], serial_i};
            RIGHT:   q_d = {serial_i, q_q[WIDTH-1:1]};
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign out_o = q_q;
endmodule

// File: rtl/shift_sequencer.sv
// Sequences one shift_register as a serializer (TX) or deserializer (RX).
// A transfer is LOAD on the accepting edge, WIDTH shift cycles, then one DONE
// cycle in which done_o (and word_valid_o for RX) pulses.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : shift_sequencer_if slave modport (handshake, word and serial
//              signals, status pulses and debug state)
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    shift_sequencer_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;   // 0 = TX, 1 = RX
    logic             msb_q, msb_d;     // 1 = MSB first

    funct_t           funct;
    logic [WIDTH-1:0] load_word;
    logic             shift_in;
    logic [WIDTH-1:0] reg_q;

    shift_register #(.WIDTH(WIDTH)) u_reg (
        .clk      (clk),
        .rst      (rst),
        .funct_i  (funct),
        .word_i   (load_word),
        .serial_i (shift_in),
        .out_o    (reg_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            msb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            msb_q   <= msb_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        msb_d     = msb_q;
        funct     = NA;
        load_word = '0;
        shift_in  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    mode_d  = bus.mode_i;
                    msb_d   = bus.msb_first_i;
                    funct   = LOAD;
                    // RX starts from a clean register so unfilled bits read 0
                    load_word = bus.mode_i ? '0 : bus.word_i;
                end
            end
            SHIFT: begin
                funct    = msb_q ? LEFT : RIGHT;
                shift_in = mode_q ? bus.serial_i : 1'b0;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The serial tap is the bit about to leave the register, so bit k of the
    // transmit order is visible in shift cycle k+1.
    assign bus.serial_o     = (state_q == SHIFT) && !mode_q &&
                              (msb_q ? reg_q[WIDTH-1] : reg_q[0]);
    assign bus.ready_o      = (state_q == IDLE);
    assign bus.busy_o       = (state_q == SHIFT) || (state_q == DONE);
    assign bus.done_o       = (state_q == DONE);
    assign bus.word_valid_o = (state_q == DONE) && mode_q;
    assign bus.word_o       = reg_q;
    assign bus.state_o      = state_q;
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Controller that sequences one `shift_register` instance as a serializer (TX) or deserializer (RX).
- Accepts a start request with a valid/ready handshake and latches mode and bit order.
- Issues LOAD/LEFT/RIGHT/NA function codes to the register for exactly WIDTH shift cycles, then reports completion.
- Sits between the parallel-word side and a single-wire serial link.

Parameters:
- WIDTH, 4, word width in bits; must be ≥2; passed to the internal `shift_register`.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start_i`  input  1  request valid; accepted only when `ready_o`=1.
- `ready_o`  output  1  high only in IDLE.
- `mode_i`  input  1  0=TX (parallel in, serial out), 1=RX (serial in, parallel out); sampled on acceptance.
- `msb_first_i`  input  1  1=MSB first (LEFT shifts), 0=LSB first (RIGHT shifts); sampled on acceptance.
- `word_i`  input  WIDTH  TX word; sampled on acceptance.
- `serial_i`  input  1  RX serial bit; sampled at the end of each SHIFT cycle.
- `serial_o`  output  1  TX serial bit.
- `word_o`  output  WIDTH  shift register contents; meaningful when `word_valid_o`=1.
- `word_valid_o`  output  1  one-cycle pulse in DONE for RX.
- `done_o`  output  1  one-cycle pulse in DONE for both modes.
- `busy_o`  output  1  high in SHIFT and DONE.

Behaviour:
- Reset values:
  - state = IDLE; bit counter, latched mode and latched order = 0.
  - Register contents = 0.
  - `ready_o`=1; `serial_o`, `word_valid_o`, `done_o`, `busy_o` = 0; `word_o`=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - funct = NA.
  - On `start_i`=1, the handshake completes at that edge ("cycle 0"):
    - latch `mode_i` and `msb_first_i`; clear the counter; go to SHIFT.
    - funct for that cycle = LOAD with `word_i` (TX) or LOAD with '0 (RX).
- SHIFT:
  - Lasts exactly WIDTH cycles (cycles 1..WIDTH).
  - funct = LEFT if the latched order is MSB-first, else RIGHT.
  - Counter increments each cycle; at count WIDTH-1 the next state is DONE.
  - Counter width is $clog2(WIDTH+1).
- TX:
  - `serial_o` = q[WIDTH-1] (MSB-first) or q[0] (LSB-first), combinational from the current register value.
  - Shift-in bit = 0.
  - Bit k of the transmit order is on `serial_o` during cycle k+1.
- RX:
  - Shift-in bit = `serial_i`.
  - MSB-first: the first received bit ends in q[WIDTH-1].
  - LSB-first: the first received bit ends in q[0].
  - `serial_o`=0 in RX mode.
- DONE:
  - One cycle (cycle WIDTH+1); funct = NA, so the register holds its value.
  - `done_o`=1; `word_valid_o`=1 only if RX.
  - Next state is IDLE unconditionally; `ready_o` rises at cycle WIDTH+2.
- `serial_o`=0 outside SHIFT.
- Register contents persist in IDLE until the next LOAD.
- `start_i` while `ready_o`=0 is ignored. There is no queueing and the in-flight transfer is unaffected.
- Inputs `mode_i`, `msb_first_i` and `word_i` changing mid-transfer have no effect.
- Reset asserted mid-SHIFT or mid-DONE: all outputs return to reset values immediately (asynchronous). The partial transfer is discarded and no `done_o` is issued.
- Transfer latency: accept → `done_o` = WIDTH+1 cycles. Minimum start-to-start spacing is WIDTH+2 cycles.

Decomposition:
- Package `shift_pkg` holds:
  - `funct_t` (NA=00, LOAD=01, LEFT=10, RIGHT=11), shared with `shift_register`;
  - `seq_state_t` (IDLE, SHIFT, DONE).
- Sub-module: one instance of `shift_register` as the datapath.
  - Sequencer drives `funct_i`, `word_i` (mux of `word_i`/'0) and `serial_i` (mux of `serial_i`/0).
  - `out_o` feeds `word_o` and the `serial_o` tap.

Test Plan:
- TX, MSB-first, `word_i`=4'b1011, `start_i` at cycle 0 → `serial_o`=1,0,1,1 in cycles 1–4; `done_o`=1 in cycle 5 only; `word_valid_o`=0; `ready_o`=1 from cycle 6.
- TX, LSB-first, `word_i`=4'b1011 → `serial_o`=1,1,0,1 in cycles 1–4; `serial_o`=0 in cycle 5.
- RX, MSB-first, `serial_i`=0,1,1,0 in cycles 1–4 → cycle 5: `word_o`=4'b0110, `word_valid_o`=1, `done_o`=1; `word_o` still 4'b0110 in later IDLE cycles.
- RX, LSB-first, `serial_i`=1,0,0,0 → cycle 5: `word_o`=4'b0001, `word_valid_o`=1.
- TX 4'b1111 started; `start_i`=1 with `word_i`=4'b0000 held in cycles 1–5 → no effect during the transfer, output remains 1,1,1,1. Because `start_i` is still high in cycle 6 (first IDLE), a second transfer is accepted there; the bench releases `start_i` by cycle 5 if no second transfer is wanted.
- TX 4'b1010; `rst` pulsed in cycle 2 → immediately `busy_o`=0, `ready_o`=1, `serial_o`=0, `word_o`=0; no `done_o` pulse. A fresh start after release completes normally.
